// File: rtl/data_io_wide.sv
// data_io_wide: io-controller SPI file download port. Packs received bytes into
// DW-bit words and writes them to RAM through a small FIFO and a wr/ack port.
module data_io_wide #(
   parameter int          DW         = 8,
   parameter int          AW         = 25,
   parameter int unsigned START_ADDR = 0,
   parameter int          FIFO_DEPTH = 4,
   parameter int          IW         = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sck,
   input  logic            ss,
   input  logic            sdi,
   output logic            downloading,
   output logic [AW-1:0]   size,
   output logic [IW-1:0]   index,
   output logic            overflow,
   output logic            wr,
   input  logic            ack,
   output logic [AW-1:0]   a,
   output logic [DW-1:0]   d,
   output logic [DW/8-1:0] be
);
   localparam int BPW = DW / 8;
   localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam logic [7:0] CMD_FILE_TX  = 8'h53;
   localparam logic [7:0] CMD_FILE_DAT = 8'h54;
   localparam logic [7:0] CMD_INDEX    = 8'h55;

   logic [2:0]     sck_q;
   logic [1:0]     ss_q, sdi_q;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [6:0]     sr_q, sr_d;
   logic           have_cmd_q, have_cmd_d;
   logic [7:0]     cmd_q, cmd_d;
   logic           stb_q, stb_d;
   logic [7:0]     stb_byte_q, stb_byte_d, stb_cmd_q, stb_cmd_d;
   logic           sck_rise_s;

   logic           dl_q, dl_d, drain_q, drain_d, ovf_q, ovf_d;
   logic [AW-1:0]  size_q, size_d, addr_q, addr_d;
   logic [DW-1:0]  pack_q, pack_d;
   logic [BPW-1:0] pbe_q, pbe_d;
   logic [IW-1:0]  index_q, index_d;
   logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]  cnt_q, cnt_d, occ_s;
   logic           wr_q, wr_d;
   logic [AW-1:0]  a_q, a_d;
   logic [DW-1:0]  d_q, d_d;
   logic [BPW-1:0] be_q, be_d;

   logic [LW-1:0]  lane_s;
   logic           push_s, push_ok_s, pop_s, flush_s;
   logic [AW-1:0]  push_a_s;
   logic [DW-1:0]  push_d_s;
   logic [BPW-1:0] push_be_s;

   logic [AW-1:0]  mem_a  [FIFO_DEPTH];
   logic [DW-1:0]  mem_d  [FIFO_DEPTH];
   logic [BPW-1:0] mem_be [FIFO_DEPTH];

   // SPI deserialiser: command byte first, then payload bytes strobed one cycle later
   always_comb begin
      sck_rise_s = sck_q[1] & ~sck_q[2];
      bit_cnt_d  = bit_cnt_q;
      sr_d       = sr_q;
      have_cmd_d = have_cmd_q;
      cmd_d      = cmd_q;
      stb_d      = 1'b0;
      stb_byte_d = stb_byte_q;
      stb_cmd_d  = stb_cmd_q;
      if (ss_q[1]) begin
         bit_cnt_d  = 3'd0;
         have_cmd_d = 1'b0;
         cmd_d      = 8'h00;
      end else if (sck_rise_s) begin
         sr_d      = {sr_q[5:0], sdi_q[1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            if (have_cmd_q) begin
               stb_d      = 1'b1;
               stb_byte_d = {sr_q, sdi_q[1]};
               stb_cmd_d  = cmd_q;
            end else begin
               have_cmd_d = 1'b1;
               cmd_d      = {sr_q, sdi_q[1]};
            end
         end else begin
         end
      end else begin
      end
   end

   // Download control, byte packing, FIFO bookkeeping and next head word
   always_comb begin
      dl_d      = dl_q;
      drain_d   = drain_q;
      ovf_d     = ovf_q;
      size_d    = size_q;
      addr_d    = addr_q;
      pack_d    = pack_q;
      pbe_d     = pbe_q;
      index_d   = index_q;
      push_s    = 1'b0;
      flush_s   = 1'b0;
      push_a_s  = addr_q;
      push_d_s  = pack_q;
      push_be_s = pbe_q;
      lane_s    = LW'(size_q % AW'(BPW));
      if (stb_q) begin
         case (stb_cmd_q)
            CMD_FILE_TX: begin
               if (stb_byte_q[0]) begin
                  dl_d    = 1'b1;
                  drain_d = 1'b0;
                  ovf_d   = 1'b0;
                  size_d  = {AW{1'b0}};
                  addr_d  = AW'(START_ADDR);
                  pack_d  = {DW{1'b0}};
                  pbe_d   = {BPW{1'b0}};
                  flush_s = 1'b1;
               end else if (dl_q && !drain_q) begin
                  drain_d = 1'b1;
                  push_s  = |pbe_q;
                  pack_d  = {DW{1'b0}};
                  pbe_d   = {BPW{1'b0}};
               end else begin
               end
            end
            CMD_FILE_DAT: begin
               if (dl_q && !drain_q) begin
                  size_d = size_q + AW'(1'b1);
                  for (int k = 0; k < BPW; k++) begin
                     if (lane_s == LW'(k)) begin
                        pack_d[8*k +: 8] = stb_byte_q;
                        pbe_d[k]         = 1'b1;
                     end else begin
                     end
                  end
                  if (lane_s == LW'(BPW - 1)) begin
                     push_s    = 1'b1;
                     push_d_s  = pack_d;
                     push_be_s = {BPW{1'b1}};
                     addr_d    = addr_q + AW'(BPW);
                     pack_d    = {DW{1'b0}};
                     pbe_d     = {BPW{1'b0}};
                  end else begin
                  end
               end else begin
               end
            end
            CMD_INDEX: index_d = IW'(stb_byte_q);
            default: ;
         endcase
      end else begin
      end

      // A pop frees a slot in the same cycle, so push-on-full with ack succeeds
      pop_s     = wr_q & ack;
      occ_s     = cnt_q - CW'(pop_s);
      push_ok_s = push_s && (occ_s < CW'(FIFO_DEPTH));
      if (push_s && !push_ok_s) begin
         ovf_d = 1'b1;
      end else begin
      end
      if (flush_s) begin
         wptr_d = {PW{1'b0}};
         rptr_d = {PW{1'b0}};
         cnt_d  = {CW{1'b0}};
      end else begin
         wptr_d = wptr_q + PW'(push_ok_s);
         rptr_d = rptr_q + PW'(pop_s);
         cnt_d  = occ_s + CW'(push_ok_s);
      end

      wr_d = (cnt_d != {CW{1'b0}});
      a_d  = a_q;
      d_d  = d_q;
      be_d = be_q;
      if (wr_d) begin
         if (occ_s == {CW{1'b0}}) begin
            a_d  = push_a_s;
            d_d  = push_d_s;
            be_d = push_be_s;
         end else begin
            a_d  = mem_a[rptr_d];
            d_d  = mem_d[rptr_d];
            be_d = mem_be[rptr_d];
         end
      end else begin
      end

      if (drain_d && (cnt_d == {CW{1'b0}})) begin
         dl_d    = 1'b0;
         drain_d = 1'b0;
      end else begin
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_a[wptr_q]  <= push_a_s;
         mem_d[wptr_q]  <= push_d_s;
         mem_be[wptr_q] <= push_be_s;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_q      <= 3'b000;
         ss_q       <= 2'b11;
         sdi_q      <= 2'b00;
         bit_cnt_q  <= 3'd0;
         sr_q       <= 7'd0;
         have_cmd_q <= 1'b0;
         cmd_q      <= 8'h00;
         stb_q      <= 1'b0;
         stb_byte_q <= 8'h00;
         stb_cmd_q  <= 8'h00;
         dl_q       <= 1'b0;
         drain_q    <= 1'b0;
         ovf_q      <= 1'b0;
         size_q     <= {AW{1'b0}};
         addr_q     <= {AW{1'b0}};
         pack_q     <= {DW{1'b0}};
         pbe_q      <= {BPW{1'b0}};
         index_q    <= {IW{1'b0}};
         wptr_q     <= {PW{1'b0}};
         rptr_q     <= {PW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         wr_q       <= 1'b0;
         a_q        <= {AW{1'b0}};
         d_q        <= {DW{1'b0}};
         be_q       <= {BPW{1'b0}};
      end else begin
         sck_q      <= {sck_q[1:0], sck};
         ss_q       <= {ss_q[0], ss};
         sdi_q      <= {sdi_q[0], sdi};
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         have_cmd_q <= have_cmd_d;
         cmd_q      <= cmd_d;
         stb_q      <= stb_d;
         stb_byte_q <= stb_byte_d;
         stb_cmd_q  <= stb_cmd_d;
         dl_q       <= dl_d;
         drain_q    <= drain_d;
         ovf_q      <= ovf_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         pack_q     <= pack_d;
         pbe_q      <= pbe_d;
         index_q    <= index_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         a_q        <= a_d;
         d_q        <= d_d;
         be_q       <= be_d;
      end
   end

   assign downloading = dl_q;
   assign size        = size_q;
   assign index       = index_q;
   assign overflow    = ovf_q;
   assign wr          = wr_q;
   assign a           = a_q;
   assign d           = d_q;
   assign be          = be_q;

endmodule

// File: doc/data_io_wide.md
Name: data_io_wide

Overview:
- Parametrised successor to the MiST io-controller download port: receives file data over the io-controller SPI link and writes it to external RAM through a buffered request/acknowledge write port.
- Runs on a single core clock. SPI lines are oversampled, so no clock-domain crossing on the write side.
- Adds a configurable data-bus width with byte packing, a write FIFO, back-pressure via ack, final partial-word flush, byte count, overflow detection, and a configurable index width.

Parameters:
- DW, 8, write data width in bits; legal values 8, 16, 32; BPW = DW/8 bytes per word.
- AW, 25, address and size width.
- START_ADDR, 0, byte address of the first downloaded byte; must be BPW-aligned.
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.
- IW, 5, width of the index output.

Ports:
- clk  in  1  core clock; must be at least 4x the SPI sck frequency.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous.
- ss  in  1  SPI select, active high = deselected, asynchronous.
- sdi  in  1  SPI data, MSB first, asynchronous.
- downloading  out  1  high from download start until the FIFO has drained after download end.
- size  out  AW  bytes received in the current or last download.
- index  out  IW  menu index from command 0x55.
- overflow  out  1  sticky; at least one byte was dropped because the FIFO was full.
- wr  out  1  write request.
- ack  in  1  RAM accepts the presented word.
- a  out  AW  byte address of byte lane 0.
- d  out  DW  write data; byte k sits on d[8k+7:8k] (little-endian).
- be  out  BPW  byte enables.

Behaviour:
- Reset (async assert, sync release):
  - downloading, overflow, wr = 0; size, index, a, d, be = 0.
  - FIFO empty; SPI bit counter = 0.
- SPI sampling:
  - sck, ss and sdi each pass through a 2-FF synchroniser.
  - A bit is taken on a detected sck rising edge while synchronised ss = 0.
  - Synchronised ss = 1 clears the bit counter and the command register immediately.
  - Bits 0-7 form the command byte; each following 8 bits form a payload byte for that command.
  - A payload byte is complete in the clk cycle after its 8th sck edge is detected.
- Command 0x53 (FILE_TX):
  - Payload bit0 = 1 (start):
    - addr and a pointer := START_ADDR; size := 0; pack buffer cleared; FIFO flushed.
    - Any wr in progress is withdrawn; overflow := 0; downloading := 1.
  - Payload bit0 = 0 (end): any partial pack buffer is pushed with be set only for the filled lanes; the drain phase begins.
- Command 0x54 (FILE_TX_DAT), only while downloading and not draining:
  - Each byte goes into lane (byte count mod BPW); size += 1, wrapping at 2^AW.
  - When the lane reaches BPW-1, push {addr, data, be = all ones}; addr += BPW.
  - Bytes arriving outside a download are ignored.
- Command 0x55: index := payload[IW-1:0]; payload bits above IW-1 are ignored.
- Other commands: payload ignored.
- FIFO full when a push is due:
  - The word is dropped and overflow := 1; size and addr still advance.
  - A push and a pop in the same cycle on a full FIFO succeed.
- Write port:
  - wr = 1 whenever the FIFO is non-empty; a, d and be show the head entry.
  - a, d and be are held stable while wr = 1 and ack = 0.
  - wr & ack in a cycle pops the entry; the next entry may be presented in the following cycle, giving back-to-back writes.
  - ack while wr = 0 is ignored.
  - After the last pop, wr = 0 and a, d, be hold their last values.
- Drain: downloading := 0 in the cycle after the FIFO becomes empty with the end command seen. With zero entries pending, that is the cycle after the end byte completes.
- Simultaneous start and pending FIFO entries: the start wins and pending entries are discarded.
- ss rising in mid-byte discards the partial byte; it does not end the download.

Test Plan:
- DW=8: 0x53/01, 0x54 with AA BB CC, 0x53/00, ack always 1 -> writes (0,AA),(1,BB),(2,CC) with be=1; size=3; downloading falls after the 3rd pop.
- DW=16, START_ADDR=0x100: five bytes 11..55 then end -> (0x100,2211,be=11),(0x102,4433,be=11),(0x104,0055,be=01); size=5.
- DW=16, ack held low 20 cycles with 10 bytes sent -> first 4 words queued, 5th dropped, overflow=1, size=10; on ack release 4 writes occur with a and d stable throughout the stall.
- Command 0x55 payload 0xE7 with IW=5 -> index=0x07; no wr activity.
- New start mid-drain with 2 entries pending -> wr drops, FIFO empty, size=0, overflow=0, next data byte written to START_ADDR.
- reset_n pulsed low mid-byte and mid-handshake -> all outputs return to reset values asynchronously; the next full 0x53/01 sequence starts cleanly.
